// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl
//   Raster timing generator for the HDMI output path. Walks an h/v counter
//   over the full raster, requests active pixels from the upstream line
//   buffer, and re-aligns the returned pixels with hsync/vsync/display-enable
//   so the hdmi block sees hve and rgb on the same cycle. Start/stop only
//   happens at frame boundaries; missing pixels are replaced and flagged.
//
// Ports
//   hdmi_clk       pixel clock (only clock)
//   reset          synchronous, active-high
//   enable         run request, sampled in IDLE and on the last cycle of a frame
//   pix_rd_en      read strobe to line buffer, one per active pixel
//   pix_x, pix_y   column / line of the current read
//   pix_data       {R,G,B} returned by the line buffer
//   pix_valid      pix_data valid, RD_LATENCY cycles after pix_rd_en
//   frame_start    one-cycle pulse at h=0,v=0 of each running frame
//   line_start     one-cycle pulse at h=0 of each running line
//   hve            {display_enable, vsync, hsync} to hdmi
//   rgb            pixel to hdmi, aligned with hve
//   underflow      sticky flag: an expected pixel did not arrive
//   underflow_clr  clears underflow (a coincident new underflow wins)
//
// RD_LATENCY is supported in the range 1..8.

module hdmi_video_timing_ctrl #(
  parameter int          H_ACTIVE      = 1280,
  parameter int          H_FP          = 110,
  parameter int          H_SYNC        = 40,
  parameter int          H_BP          = 220,
  parameter int          V_ACTIVE      = 720,
  parameter int          V_FP          = 5,
  parameter int          V_SYNC        = 5,
  parameter int          V_BP          = 20,
  parameter logic        HS_POL        = 1'b1,
  parameter logic        VS_POL        = 1'b1,
  parameter int          RD_LATENCY    = 2,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        hdmi_clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pix_rd_en,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        frame_start,
  output logic        line_start,
  output logic [2:0]  hve,
  output logic [23:0] rgb,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // hve leaves the pipe RD_LATENCY+2 cycles after stage 0.
  localparam int PIPE_LEN = RD_LATENCY + 2;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  IDLE_HVE = {1'b0, ~VS_POL, ~HS_POL};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_p0, v_p0;
  logic [11:0] h_d, v_d;
  logic        run_p0, de_p0, hs_p0, vs_p0;
  logic        fs_p0, ls_p0;
  logic [2:0]  hve_pipe [PIPE_LEN];
  logic        slot_exp;

  // Stage 0: counters and the raw timing derived from them
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      state_q <= IDLE;
      h_p0    <= '0;
      v_p0    <= '0;
    end else begin
      state_q <= state_d;
      h_p0    <= h_d;
      v_p0    <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_p0;
    v_d     = v_p0;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (h_p0 == H_LAST) begin
          h_d = '0;
          if (v_p0 == V_LAST) begin
            v_d = '0;
            // Only the final cycle of a frame may stop the raster.
            if (!enable) state_d = IDLE;
          end else begin
            v_d = v_p0 + 12'd1;
          end
        end else begin
          h_d = h_p0 + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_p0 = (state_q == RUN);
    de_p0  = run_p0 && (h_p0 < H_ACT) && (v_p0 < V_ACT);
    hs_p0  = (run_p0 && (h_p0 >= HS_START) && (h_p0 < HS_END)) ? HS_POL : ~HS_POL;
    vs_p0  = (run_p0 && (v_p0 >= VS_START) && (v_p0 < VS_END)) ? VS_POL : ~VS_POL;
    fs_p0  = run_p0 && (h_p0 == 12'd0) && (v_p0 == 12'd0);
    ls_p0  = run_p0 && (h_p0 == 12'd0);
  end

  // Stage 1: read request and position pulses
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      pix_rd_en   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      pix_rd_en   <= de_p0;
      pix_x       <= h_p0;
      pix_y       <= v_p0;
      frame_start <= fs_p0;
      line_start  <= ls_p0;
    end
  end

  // Stages 1..RD_LATENCY+2: sync delay line. It keeps shifting while idle
  // so that the output flushes to the idle levels after a stop.
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_LEN; k++) hve_pipe[k] <= IDLE_HVE;
    end else begin
      hve_pipe[0] <= {de_p0, vs_p0, hs_p0};
      for (int k = 1; k < PIPE_LEN; k++) hve_pipe[k] <= hve_pipe[k-1];
    end
  end

  // The de tap RD_LATENCY+1 cycles after stage 0 marks the cycle in which
  // the line buffer should be presenting the requested pixel.
  assign slot_exp = hve_pipe[RD_LATENCY][2];
  assign hve      = hve_pipe[PIPE_LEN-1];

  // Stage RD_LATENCY+2: pixel output register and underflow flag
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      rgb       <= '0;
      underflow <= 1'b0;
    end else begin
      if (slot_exp) rgb <= pix_valid ? pix_data : UNDERFLOW_RGB;
      else          rgb <= '0;
      if (slot_exp && !pix_valid) underflow <= 1'b1;
      else if (underflow_clr)     underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Directed bench for hdmi_video_timing_ctrl using a 14x7 raster
// (H 8/2/2/2, V 4/1/1/1) and RD_LATENCY=2. An ideal line buffer returns
// {y,x} two cycles after each read; it can drop pixel (3,1) on request.
// A second instance with inverted sync polarity covers the polarity case.
// Cycle index c=0 is the first RUN cycle; frame_start is seen at c=1 and
// hve/rgb at cycle c reflect raster position c-4.

module tb_hdmi_video_timing_ctrl;

  logic        hdmi_clk = 1'b0;
  logic        reset, enable, underflow_clr;
  logic        pix_rd_en, pix_valid, frame_start, line_start, underflow;
  logic [11:0] pix_x, pix_y;
  logic [23:0] pix_data, rgb;
  logic [2:0]  hve;

  logic        en_n;
  logic        pix_rd_en_n, frame_start_n, line_start_n, underflow_n;
  logic [11:0] pix_x_n, pix_y_n;
  logic [23:0] rgb_n;
  logic [2:0]  hve_n;

  logic        drop_en = 1'b0;
  logic [1:0]  bv = 2'b00;
  logic [11:0] bx0 = '0, bx1 = '0, by0 = '0, by1 = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 hdmi_clk = ~hdmi_clk;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LATENCY(2), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut (
    .hdmi_clk(hdmi_clk), .reset(reset), .enable(enable),
    .pix_rd_en(pix_rd_en), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .line_start(line_start),
    .hve(hve), .rgb(rgb), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LATENCY(2), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut_n (
    .hdmi_clk(hdmi_clk), .reset(reset), .enable(en_n),
    .pix_rd_en(pix_rd_en_n), .pix_x(pix_x_n), .pix_y(pix_y_n),
    .pix_data(24'h000000), .pix_valid(1'b0),
    .frame_start(frame_start_n), .line_start(line_start_n),
    .hve(hve_n), .rgb(rgb_n), .underflow(underflow_n), .underflow_clr(1'b0)
  );

  // Ideal line buffer: two-cycle read latency, data = {y,x}.
  always @(posedge hdmi_clk) begin
    bv  <= {bv[0], pix_rd_en};
    bx0 <= pix_x;
    bx1 <= bx0;
    by0 <= pix_y;
    by1 <= by0;
  end
  assign pix_valid = bv[1] && !(drop_en && bx1 == 12'd3 && by1 == 12'd1);
  assign pix_data  = {by1, bx1};

  task automatic tick();
    @(posedge hdmi_clk);
    @(negedge hdmi_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; en_n = 1'b0; underflow_clr = 1'b0;
    tick(); tick(); tick();
    chk_cnt++; if (hve !== 3'b000) $display("FAIL reset_hve got %b want 000", hve); else pass_cnt++;
    chk_cnt++; if (rgb !== 24'h0) $display("FAIL reset_rgb got %h want 000000", rgb); else pass_cnt++;
    chk_cnt++; if (pix_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", pix_rd_en); else pass_cnt++;
    chk_cnt++; if (pix_x !== 12'd0 || pix_y !== 12'd0) $display("FAIL reset_xy got %0d,%0d want 0,0", pix_x, pix_y); else pass_cnt++;
    chk_cnt++; if (frame_start !== 1'b0 || line_start !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", frame_start, line_start); else pass_cnt++;
    chk_cnt++; if (underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow); else pass_cnt++;
    chk_cnt++; if (hve_n !== 3'b011) $display("FAIL reset_hve_n got %b want 011", hve_n); else pass_cnt++;
    reset = 1'b0;
    tick(); tick();
    chk_cnt++; if (pix_rd_en !== 1'b0 || frame_start !== 1'b0) $display("FAIL idle_quiet got rd=%b fs=%b want 0,0", pix_rd_en, frame_start); else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    int fs_cnt, rd_cnt, uf_cnt;
    fs_cnt = 0; rd_cnt = 0; uf_cnt = 0;
    enable = 1'b1;
    tick();
    for (int c = 0; c < 196; c++) begin
      if (frame_start === 1'b1) fs_cnt++;
      if (c >= 1 && c <= 98 && pix_rd_en === 1'b1) rd_cnt++;
      if (underflow !== 1'b0) uf_cnt++;
      if (c == 1) begin
        chk_cnt++; if (frame_start !== 1'b1) $display("FAIL fs_first got %b want 1", frame_start); else pass_cnt++;
        chk_cnt++; if (pix_rd_en !== 1'b1 || pix_x !== 12'd0 || pix_y !== 12'd0) $display("FAIL rd_first got rd=%b x=%0d y=%0d want 1,0,0", pix_rd_en, pix_x, pix_y); else pass_cnt++;
      end
      if (c == 99) begin
        chk_cnt++; if (frame_start !== 1'b1) $display("FAIL fs_period got %b want 1 at c=99", frame_start); else pass_cnt++;
      end
      if (c == 15) begin
        chk_cnt++; if (line_start !== 1'b1) $display("FAIL ls_line1 got %b want 1", line_start); else pass_cnt++;
      end
      if (c == 3) begin
        chk_cnt++; if (hve !== 3'b000) $display("FAIL hve_pre got %b want 000", hve); else pass_cnt++;
      end
      if (c == 4) begin
        chk_cnt++; if (hve !== 3'b100 || rgb !== 24'h000000) $display("FAIL align_x0 got hve=%b rgb=%h want 100,000000", hve, rgb); else pass_cnt++;
      end
      if (c == 11) begin
        chk_cnt++; if (hve !== 3'b100 || rgb !== 24'h000007) $display("FAIL align_x7 got hve=%b rgb=%h want 100,000007", hve, rgb); else pass_cnt++;
      end
      if (c == 12) begin
        chk_cnt++; if (hve !== 3'b000 || rgb !== 24'h000000) $display("FAIL align_blank got hve=%b rgb=%h want 000,000000", hve, rgb); else pass_cnt++;
      end
      if (c == 18) begin
        chk_cnt++; if (rgb !== 24'h001000) $display("FAIL align_y1 got %h want 001000", rgb); else pass_cnt++;
      end
      if (c == 53) begin
        chk_cnt++; if (rgb !== 24'h003007) $display("FAIL align_y3x7 got %h want 003007", rgb); else pass_cnt++;
      end
      if (c == 60) begin
        chk_cnt++; if (hve !== 3'b000 || rgb !== 24'h000000) $display("FAIL vblank_line4 got hve=%b rgb=%h want 000,000000", hve, rgb); else pass_cnt++;
      end
      if (c == 13) begin
        chk_cnt++; if (hve !== 3'b000) $display("FAIL hs_before got %b want 000", hve); else pass_cnt++;
      end
      if (c == 14 || c == 15) begin
        chk_cnt++; if (hve !== 3'b001) $display("FAIL hs_active c=%0d got %b want 001", c, hve); else pass_cnt++;
      end
      if (c == 16) begin
        chk_cnt++; if (hve !== 3'b000) $display("FAIL hs_after got %b want 000", hve); else pass_cnt++;
      end
      if (c == 73 || c == 88) begin
        chk_cnt++; if (hve !== 3'b000) $display("FAIL vs_edge c=%0d got %b want 000", c, hve); else pass_cnt++;
      end
      if (c == 74 || c == 87) begin
        chk_cnt++; if (hve !== 3'b010) $display("FAIL vs_line c=%0d got %b want 010", c, hve); else pass_cnt++;
      end
      if (c == 84) begin
        chk_cnt++; if (hve !== 3'b011) $display("FAIL vs_hs got %b want 011", hve); else pass_cnt++;
      end
      tick();
    end
    chk_cnt++; if (fs_cnt != 2) $display("FAIL fs_count got %0d want 2", fs_cnt); else pass_cnt++;
    chk_cnt++; if (rd_cnt != 32) $display("FAIL rd_count got %0d want 32", rd_cnt); else pass_cnt++;
    chk_cnt++; if (uf_cnt != 0) $display("FAIL no_underflow got %0d flagged cycles want 0", uf_cnt); else pass_cnt++;
  endtask

  task automatic test_underflow();
    int n;
    drop_en = 1'b1;
    n = 0;
    while (frame_start !== 1'b1 && n < 300) begin tick(); n++; end
    chk_cnt++; if (frame_start !== 1'b1) $display("FAIL uf_sync got %b want 1 within 300 cycles", frame_start); else pass_cnt++;
    for (int c = 1; c <= 125; c++) begin
      if (c == 20) begin
        chk_cnt++; if (underflow !== 1'b0) $display("FAIL uf_before got %b want 0", underflow); else pass_cnt++;
      end
      if (c == 21 || c == 119) begin
        chk_cnt++; if (rgb !== 24'hFF00FF || hve !== 3'b100) $display("FAIL uf_rgb c=%0d got rgb=%h hve=%b want FF00FF,100", c, rgb, hve); else pass_cnt++;
        chk_cnt++; if (underflow !== 1'b1) $display("FAIL uf_set c=%0d got %b want 1", c, underflow); else pass_cnt++;
      end
      if (c == 22) begin
        chk_cnt++; if (rgb !== 24'h001004 || underflow !== 1'b1) $display("FAIL uf_sticky got rgb=%h uf=%b want 001004,1", rgb, underflow); else pass_cnt++;
      end
      if (c == 26 || c == 100) begin
        chk_cnt++; if (underflow !== 1'b0) $display("FAIL uf_clr c=%0d got %b want 0", c, underflow); else pass_cnt++;
      end
      underflow_clr = (c == 25 || c == 118);
      tick();
    end
    underflow_clr = 1'b0;
    drop_en = 1'b0;
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk_cnt++; if (underflow !== 1'b0) $display("FAIL uf_final_clr got %b want 0", underflow); else pass_cnt++;
  endtask

  task automatic test_stop_boundary();
    int n, ls_cnt, rd_cnt, fs_cnt, late_cnt;
    ls_cnt = 0; rd_cnt = 0; fs_cnt = 0; late_cnt = 0;
    n = 0;
    while (frame_start !== 1'b1 && n < 300) begin tick(); n++; end
    chk_cnt++; if (frame_start !== 1'b1) $display("FAIL stop_sync got %b want 1 within 300 cycles", frame_start); else pass_cnt++;
    for (int c = 1; c <= 135; c++) begin
      if (c <= 98 && line_start === 1'b1) ls_cnt++;
      if (c <= 98 && pix_rd_en === 1'b1) rd_cnt++;
      if (c >= 2 && c <= 131 && frame_start !== 1'b0) fs_cnt++;
      if (c >= 99 && c <= 131 && (pix_rd_en !== 1'b0 || line_start !== 1'b0)) late_cnt++;
      if (c == 102) begin
        chk_cnt++; if (hve !== 3'b000 || rgb !== 24'h0) $display("FAIL stop_hve got hve=%b rgb=%h want 000,000000", hve, rgb); else pass_cnt++;
      end
      if (c == 110) begin
        chk_cnt++; if (pix_x !== 12'd0 || pix_y !== 12'd0) $display("FAIL stop_frozen got %0d,%0d want 0,0", pix_x, pix_y); else pass_cnt++;
      end
      if (c == 132) begin
        chk_cnt++; if (frame_start !== 1'b1) $display("FAIL restart_fs got %b want 1", frame_start); else pass_cnt++;
      end
      if (c == 29) enable = 1'b0;
      if (c == 130) enable = 1'b1;
      tick();
    end
    chk_cnt++; if (ls_cnt != 7) $display("FAIL stop_ls_count got %0d want 7", ls_cnt); else pass_cnt++;
    chk_cnt++; if (rd_cnt != 32) $display("FAIL stop_rd_count got %0d want 32", rd_cnt); else pass_cnt++;
    chk_cnt++; if (fs_cnt != 0) $display("FAIL stop_no_fs got %0d want 0", fs_cnt); else pass_cnt++;
    chk_cnt++; if (late_cnt != 0) $display("FAIL stop_idle_quiet got %0d want 0", late_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_midline();
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 300) begin tick(); n++; end
    chk_cnt++; if (frame_start !== 1'b1) $display("FAIL rst_sync got %b want 1 within 300 cycles", frame_start); else pass_cnt++;
    for (int c = 1; c <= 40; c++) begin
      if (c == 33) begin
        chk_cnt++; if (pix_x !== 12'd4 || pix_y !== 12'd2) $display("FAIL rst_pos got %0d,%0d want 4,2", pix_x, pix_y); else pass_cnt++;
      end
      if (c == 34) begin
        chk_cnt++; if (pix_rd_en !== 1'b0 || pix_x !== 12'd0 || pix_y !== 12'd0) $display("FAIL rst_rd got rd=%b x=%0d y=%0d want 0,0,0", pix_rd_en, pix_x, pix_y); else pass_cnt++;
        chk_cnt++; if (hve !== 3'b000 || rgb !== 24'h0) $display("FAIL rst_hve got hve=%b rgb=%h want 000,000000", hve, rgb); else pass_cnt++;
        chk_cnt++; if (frame_start !== 1'b0 || line_start !== 1'b0 || underflow !== 1'b0) $display("FAIL rst_flags got %b%b%b want 000", frame_start, line_start, underflow); else pass_cnt++;
      end
      if (c == 35) begin
        chk_cnt++; if (frame_start !== 1'b0) $display("FAIL rst_fs_early got %b want 0", frame_start); else pass_cnt++;
      end
      if (c == 36) begin
        chk_cnt++; if (frame_start !== 1'b1 || pix_rd_en !== 1'b1 || pix_x !== 12'd0 || pix_y !== 12'd0) $display("FAIL rst_restart got fs=%b rd=%b x=%0d y=%0d want 1,1,0,0", frame_start, pix_rd_en, pix_x, pix_y); else pass_cnt++;
      end
      if (c == 40) begin
        chk_cnt++; if (hve !== 3'b100 || rgb !== 24'h000001) $display("FAIL rst_align got hve=%b rgb=%h want 100,000001", hve, rgb); else pass_cnt++;
      end
      if (c == 33) reset = 1'b1;
      if (c == 34) reset = 1'b0;
      tick();
    end
  endtask

  task automatic test_polarity();
    int n;
    chk_cnt++; if (hve_n !== 3'b011) $display("FAIL pol_idle got %b want 011", hve_n); else pass_cnt++;
    en_n = 1'b1;
    n = 0;
    while (frame_start_n !== 1'b1 && n < 300) begin tick(); n++; end
    chk_cnt++; if (frame_start_n !== 1'b1) $display("FAIL pol_sync got %b want 1 within 300 cycles", frame_start_n); else pass_cnt++;
    for (int c = 1; c <= 90; c++) begin
      if (c == 4) begin
        chk_cnt++; if (hve_n !== 3'b111) $display("FAIL pol_de got %b want 111", hve_n); else pass_cnt++;
      end
      if (c == 13 || c == 16) begin
        chk_cnt++; if (hve_n !== 3'b011) $display("FAIL pol_hs_idle c=%0d got %b want 011", c, hve_n); else pass_cnt++;
      end
      if (c == 14 || c == 15) begin
        chk_cnt++; if (hve_n !== 3'b010) $display("FAIL pol_hs c=%0d got %b want 010", c, hve_n); else pass_cnt++;
      end
      if (c == 74) begin
        chk_cnt++; if (hve_n !== 3'b001) $display("FAIL pol_vs got %b want 001", hve_n); else pass_cnt++;
      end
      if (c == 84) begin
        chk_cnt++; if (hve_n !== 3'b000) $display("FAIL pol_vs_hs got %b want 000", hve_n); else pass_cnt++;
      end
      tick();
    end
    en_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underflow();
    test_stop_boundary();
    test_reset_midline();
    test_polarity();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
